// File: rtl/line_clear_engine.sv
// line_clear_engine: takes a settled board, removes every full row over several cycles,
// then spawns the next piece at the top and reports collisions and the cleared-row count.
module line_clear_engine #(
    parameter int COLS      = 4,
    parameter int ROWS      = 8,
    parameter int SPAWN_COL = 1
) (
    input  logic                       clka,
    input  logic                       restart,
    input  logic                       start,
    input  logic [ROWS*COLS-1:0]       board_in,
    input  logic [1:0]                 curr_piece,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*COLS-1:0]       board_out,
    output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
    output logic                       error
);
    localparam int N  = ROWS*COLS;
    localparam int PW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS+1);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   board_q, board_d, out_q, out_d;
    logic [1:0]     piece_q, piece_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [LW-1:0]  cnt_q, cnt_d, lines_q, lines_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           full;
    logic [N-1:0]   low_mask, shifted, mask;

    assign full     = board_q[ptr_q*COLS +: COLS] == {COLS{1'b1}};
    // Rows 0..ptr move down one row; row 0 is refilled with zeros by the shift.
    assign low_mask = {N{1'b1}} >> ((ROWS-1-ptr_q)*COLS);
    assign shifted  = ((board_q << COLS) & low_mask) | (board_q & ~low_mask);
    assign mask     = (ONE << SPAWN_COL)
                    | ((piece_q == 2'b01 || piece_q == 2'b10) ? (ONE << (SPAWN_COL+1)) : '0)
                    | (piece_q[1] ? ((ONE << (COLS+SPAWN_COL)) | (ONE << (COLS+SPAWN_COL+1))) : '0);

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= IDLE;
            board_q <= '0;
            out_q   <= '0;
            piece_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            out_q   <= out_d;
            piece_q <= piece_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        out_d   = out_q;
        piece_d = piece_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                board_d = board_in;
                piece_d = curr_piece;
                ptr_d   = PW'(ROWS-1);
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (full) begin
                board_d = shifted;
                cnt_d   = cnt_q + 1'b1;
            end else if (ptr_q == '0) begin
                state_d = SPAWN;
            end else begin
                ptr_d = ptr_q - 1'b1;
            end
            SPAWN: begin
                err_d   = |(mask & board_q);
                out_d   = board_q | mask;
                lines_d = cnt_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign board_out     = out_q;
    assign lines_cleared = lines_q;
    assign error         = err_q;
endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: directed vectors against the default 4x8 engine and a 6x10 variant.
module tb_line_clear_engine;
    logic        clk = 1'b0, restart = 1'b1;
    logic        start = 1'b0, start6 = 1'b0;
    logic [31:0] board_in = '0;
    logic [59:0] board_in6 = '0;
    logic [1:0]  curr_piece = '0, curr_piece6 = '0;
    logic        busy, done, error, busy6, done6, error6;
    logic [31:0] board_out;
    logic [59:0] board_out6;
    logic [3:0]  lines_cleared, lines_cleared6;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    line_clear_engine dut (
        .clka(clk), .restart(restart), .start(start), .board_in(board_in),
        .curr_piece(curr_piece), .busy(busy), .done(done), .board_out(board_out),
        .lines_cleared(lines_cleared), .error(error)
    );

    line_clear_engine #(.COLS(6), .ROWS(10), .SPAWN_COL(2)) dut6 (
        .clka(clk), .restart(restart), .start(start6), .board_in(board_in6),
        .curr_piece(curr_piece6), .busy(busy6), .done(done6), .board_out(board_out6),
        .lines_cleared(lines_cleared6), .error(error6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ec = edges from the start-sampling edge up to and including the one that raises done.
    task automatic run(input string tag, input logic [31:0] b, input logic [1:0] p,
                       input logic [31:0] eb, input int el, input logic ee, input int ec,
                       input bit poke);
        int cyc = 0, bz = 0, nd = 0;
        @(negedge clk);
        board_in = b; curr_piece = p; start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            board_in = ~b;
            start = poke && cyc == 3;
            if (!busy) bz++;
        end while (!done && cyc < 60);
        check({tag, "_latency"}, cyc, ec);
        check({tag, "_busy_run"}, bz, 0);
        check({tag, "_board"}, board_out, eb);
        check({tag, "_lines"}, lines_cleared, el);
        check({tag, "_error"}, error, ee);
        start = poke;
        bz = 0;
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
            if (busy) bz++;
        end
        check({tag, "_extra_done"}, nd, 0);
        check({tag, "_busy_idle"}, bz, 0);
        check({tag, "_hold"}, board_out, eb);
    endtask

    initial begin
        int cyc, nd;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_board", board_out, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_error", error, 0);
        restart = 1'b0;

        run("empty",  32'h00000000, 2'b10, 32'h00000066, 0, 1'b0, 10, 1'b0);
        run("bottom", 32'hF0000000, 2'b00, 32'h00000002, 1, 1'b0, 11, 1'b0);
        run("split",  32'hF1F20000, 2'b01, 32'h12000006, 2, 1'b0, 12, 1'b0);
        run("full",   32'hFFFFFFFF, 2'b00, 32'h00000002, 8, 1'b0, 18, 1'b1);
        run("coll",   32'h00000020, 2'b11, 32'h00000062, 0, 1'b1, 10, 1'b0);

        @(negedge clk);
        board_in = 32'hF0000000; curr_piece = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_board", board_out, 0);
        check("abort_error", error, 0);
        check("abort_lines", lines_cleared, 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);

        run("after", 32'h0000F000, 2'b00, 32'h00000002, 1, 1'b0, 11, 1'b0);

        @(negedge clk);
        board_in6 = 60'hFC0000000000000; curr_piece6 = 2'b00; start6 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start6 = 1'b0;
        end while (!done6 && cyc < 60);
        check("p6_latency", cyc, 13);
        check("p6_board", board_out6, 60'h4);
        check("p6_lines", lines_cleared6, 1);
        check("p6_error", error6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
